// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon-AEAD128 types, constants and the single-round function used by
// the permutation datapath.
package ascon_aead128_pkg;

    typedef struct packed {
        logic [63:0] s0;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] s3;
        logic [63:0] s4;
    } ascon_state;

    typedef enum logic [1:0] {
        P12 = 2'd0,
        P8  = 2'd1,
        P6  = 2'd2
    } ascon_perm_mode;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ascon_perm_fsm_state;

    // Starting round index: the permutation always finishes at index 15.
    localparam logic [3:0] P12_INIT = 4'h4;
    localparam logic [3:0] P8_INIT  = 4'h8;
    localparam logic [3:0] P6_INIT  = 4'hA;

    localparam logic [7:0] const_add [16] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    // Indexed by {s0,s1,s2,s3,s4} bit column, s0 as MSB.
    localparam logic [4:0] s_box [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic ascon_state round(input ascon_state s, input logic [7:0] rc);
        ascon_state x;
        ascon_state y;
        ascon_state o;
        logic [4:0] col;
        logic [4:0] sub;
        x = s;
        x.s2[7:0] = x.s2[7:0] ^ rc;
        y = '0;
        for (int i = 0; i < 64; i++) begin
            col = {x.s0[i], x.s1[i], x.s2[i], x.s3[i], x.s4[i]};
            sub = s_box[col];
            y.s0[i] = sub[4];
            y.s1[i] = sub[3];
            y.s2[i] = sub[2];
            y.s3[i] = sub[1];
            y.s4[i] = sub[0];
        end
        o.s0 = y.s0 ^ rotr(y.s0, 19) ^ rotr(y.s0, 28);
        o.s1 = y.s1 ^ rotr(y.s1, 61) ^ rotr(y.s1, 39);
        o.s2 = y.s2 ^ rotr(y.s2, 1)  ^ rotr(y.s2, 6);
        o.s3 = y.s3 ^ rotr(y.s3, 10) ^ rotr(y.s3, 17);
        o.s4 = y.s4 ^ rotr(y.s4, 7)  ^ rotr(y.s4, 41);
        return o;
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear diffusion.
module ascon_round
    import ascon_aead128_pkg::*;
(
    input  ascon_state state_in,
    input  logic [7:0] rc,
    output ascon_state state_out
);

    assign state_out = round(state_in, rc);

endmodule

// File: rtl/ascon_perm_unit.sv
// Ascon permutation engine (p12/p8/p6) with UNROLL rounds per clock and a
// valid/ready job interface on both sides.
//
// state | meaning
// IDLE  | no job held, ready for a new one
// RUN   | rounds in progress, r = next round index
// DONE  | result held on state_out until out_ready
module ascon_perm_unit
    import ascon_aead128_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   mode,
    input  logic [319:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] state_out,
    output logic         busy
);

    ascon_perm_fsm_state fsm_q, fsm_d;
    ascon_state          state_q, state_d;
    logic [4:0]          r_q, r_d;
    logic [4:0]          r_sum;
    logic                last;
    logic [3:0]          r_init;
    ascon_state          stage [UNROLL+1];

    assign stage[0] = state_q;

    // Stages whose round index would pass 15 are bypassed so the final
    // partial cycle applies exactly the remaining rounds.
    for (genvar g = 0; g < UNROLL; g++) begin : g_stage
        logic [4:0] idx;
        logic       active;
        ascon_state rnd_out;
        assign idx    = r_q + 5'(g);
        assign active = (idx < 5'd16);
        ascon_round u_round (
            .state_in  (stage[g]),
            .rc        (const_add[idx[3:0]]),
            .state_out (rnd_out)
        );
        assign stage[g+1] = active ? rnd_out : stage[g];
    end

    assign r_sum = r_q + 5'(UNROLL);
    assign last  = (r_sum >= 5'd16);

    always_comb begin
        case (mode)
            P8:      r_init = P8_INIT;
            P6:      r_init = P6_INIT;
            default: r_init = P12_INIT;
        endcase
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        r_d     = r_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = ascon_state'(state_in);
                    r_d     = {1'b0, r_init};
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = stage[UNROLL];
                r_d     = last ? 5'd16 : r_sum;
                if (last) fsm_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = ascon_state'(state_in);
                        r_d     = {1'b0, r_init};
                        fsm_d   = RUN;
                    end else begin
                        fsm_d = IDLE;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            r_q     <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    // rst_n gate keeps in_ready low while reset is held, even though fsm_q is IDLE.
    assign in_ready  = rst_n && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN);
    assign state_out = state_q;

endmodule

// File: tb/tb_ascon_perm_unit.sv
// Self-checking bench: four units (UNROLL=1..4) against a bit-sliced Ascon model.
module tb_ascon_perm_unit;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv   [4];
    logic         ir   [4];
    logic [1:0]   md   [4];
    logic [319:0] si   [4];
    logic         ov   [4];
    logic         ordy [4];
    logic [319:0] so   [4];
    logic         bz   [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar u = 0; u < 4; u++) begin : g_dut
        ascon_perm_unit #(.UNROLL(u + 1)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[u]),
            .in_ready  (ir[u]),
            .mode      (md[u]),
            .state_in  (si[u]),
            .out_valid (ov[u]),
            .out_ready (ordy[u]),
            .state_out (so[u]),
            .busy      (bz[u])
        );
    end

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference permutation in the bit-sliced form of the Ascon C reference.
    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
        logic [63:0] x [5];
        logic [63:0] t [5];
        for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
        for (int i = 0; i < n; i++) begin
            int j;
            j = 12 - n + i;
            x[2] = x[2] ^ 64'((15 - j) * 16 + j);
            x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
            for (int k = 0; k < 5; k++) t[k] = ~x[k] & x[(k + 1) % 5];
            for (int k = 0; k < 5; k++) x[k] ^= t[(k + 1) % 5];
            x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
            x[0] ^= rr(x[0], 19) ^ rr(x[0], 28);
            x[1] ^= rr(x[1], 61) ^ rr(x[1], 39);
            x[2] ^= rr(x[2], 1)  ^ rr(x[2], 6);
            x[3] ^= rr(x[3], 10) ^ rr(x[3], 17);
            x[4] ^= rr(x[4], 7)  ^ rr(x[4], 41);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int rounds_of(input logic [1:0] m);
        return (m == 2'd1) ? 8 : (m == 2'd2) ? 6 : 12;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Runs one job on unit u; out_ready is held low for 'hold' cycles once out_valid rises.
    task automatic run_job(input int u, input logic [1:0] m, input logic [319:0] s,
                           input int exp_lat, input int hold);
        logic [319:0] exp;
        int lat;
        exp = ref_perm(s, rounds_of(m));
        @(negedge clk);
        check("in_ready_idle", 320'(ir[u]), 320'(1));
        iv[u] = 1'b1; md[u] = m; si[u] = s; ordy[u] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        iv[u] = 1'b0; md[u] = 2'(~m); si[u] = rand320();
        check("busy_run", 320'(bz[u]), 320'(1));
        lat = 1;
        while (!ov[u] && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            if (!ov[u]) lat++;
        end
        check("latency", 320'(lat), 320'(exp_lat));
        check("result", so[u], exp);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_state", so[u], exp);
            check("hold_valid", 320'(ov[u]), 320'(1));
            check("hold_in_ready", 320'(ir[u]), 320'(0));
            check("hold_busy", 320'(bz[u]), 320'(0));
        end
        ordy[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("valid_cleared", 320'(ov[u]), 320'(0));
    endtask

    typedef struct {
        int         u;
        logic [1:0] m;
        int         lat;
    } vec_t;

    vec_t vecs [14];

    initial begin
        for (int u = 0; u < 4; u++) begin
            iv[u] = 1'b0; md[u] = 2'd0; si[u] = '0; ordy[u] = 1'b1;
        end
        vecs = '{
            '{0, 2'd0, 12}, '{0, 2'd1, 8}, '{0, 2'd2, 6}, '{0, 2'd3, 12},
            '{1, 2'd0, 6},  '{1, 2'd1, 4}, '{1, 2'd2, 3},
            '{2, 2'd0, 4},  '{2, 2'd1, 3}, '{2, 2'd2, 2},
            '{3, 2'd0, 3},  '{3, 2'd1, 2}, '{3, 2'd2, 2}, '{3, 2'd3, 3}
        };

        // Reset values while rst_n is held low.
        @(negedge clk);
        check("rst_state_out", so[0], '0);
        check("rst_out_valid", 320'(ov[0]), 320'(0));
        check("rst_busy", 320'(bz[0]), 320'(0));
        check("rst_in_ready", 320'(ir[0]), 320'(0));
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_rst", 320'(ir[3]), 320'(1));

        // p12 of the all-zero state on UNROLL=1.
        run_job(0, 2'd0, '0, 12, 0);

        for (int i = 0; i < 14; i++)
            run_job(vecs[i].u, vecs[i].m, rand320(), vecs[i].lat, 0);

        // Backpressure: result held for 5 cycles.
        run_job(0, 2'd2, rand320(), 6, 5);
        run_job(3, 2'd1, rand320(), 2, 5);

        // Back-to-back p12 jobs on UNROLL=2 with in_valid held high.
        begin
            logic [319:0] jobs [3];
            int lat;
            for (int k = 0; k < 3; k++) jobs[k] = rand320();
            @(negedge clk);
            iv[1] = 1'b1; md[1] = 2'd0; si[1] = jobs[0]; ordy[1] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk);
                @(negedge clk);
                check("b2b_busy", 320'(bz[1]), 320'(1));
                si[1] = (k < 2) ? jobs[k+1] : '0;
                md[1] = 2'd2;
                lat = 1;
                while (!ov[1] && lat < 40) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (!ov[1]) lat++;
                end
                check("b2b_latency", 320'(lat), 320'(6));
                check("b2b_result", so[1], ref_perm(jobs[k], 12));
                check("b2b_in_ready", 320'(ir[1]), 320'(1));
                md[1] = 2'd0;
                if (k == 2) iv[1] = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("b2b_idle", 320'(ov[1]), 320'(0));
        end

        // Reset pulsed mid-RUN.
        @(negedge clk);
        iv[0] = 1'b1; md[0] = 2'd0; si[0] = rand320(); ordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_state_out", so[0], '0);
        check("midrst_out_valid", 320'(ov[0]), 320'(0));
        check("midrst_busy", 320'(bz[0]), 320'(0));
        check("midrst_in_ready", 320'(ir[0]), 320'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", 320'(ir[0]), 320'(1));
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 15; c++) begin
                if (ov[0] || bz[0]) seen++;
                @(negedge clk);
            end
            check("post_rst_no_output", 320'(seen), 320'(0));
        end

        run_job(2, 2'd0, rand320(), 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ascon_perm_unit.md
ASCON_PERM_UNIT -- requirements
Module: ascon_perm_unit

Interface
REQ-001 SHALL have parameter UNROLL, default 1, legal range 1..4: number of permutation rounds computed per clock cycle.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  state_in and mode are valid.
REQ-005 SHALL have port in_ready  output  1  unit accepts a new permutation job.
REQ-006 SHALL have port mode  input  2  round count select: 0 = p12, 1 = p8, 2 = p6, 3 = reserved (treated as p12).
REQ-007 SHALL have port state_in  input  320  ascon_state, s0 in the MSBs.
REQ-008 SHALL have port out_valid  output  1  state_out holds a completed permutation.
REQ-009 SHALL have port out_ready  input  1  consumer accepts state_out.
REQ-010 SHALL have port state_out  output  320  permuted ascon_state.
REQ-011 SHALL have port busy  output  1  high while rounds are in progress.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready = (IDLE) or (DONE and out_ready).
REQ-014 SHALL, on an input handshake (in_valid and in_ready), perform the following:
- load state_in into the state register;
- load the round index r with 16-N, where N = 12/8/6 (index 4/8/10);
- enter RUN.
REQ-015 SHALL, on each RUN edge, apply k = min(UNROLL, 16-r) chained rounds using constants const_add[r] .. const_add[r+k-1], then advance r by k.
REQ-016 SHALL bypass unrolled stages beyond k in a partial final cycle, so the state sees exactly N rounds.
REQ-017 SHALL enter DONE and raise out_valid on the edge that completes round index 15.
REQ-018 SHALL have latency ceil(N/UNROLL) cycles from the input-handshake edge to the edge that raises out_valid.
REQ-019 SHALL make each round the following three steps, in order:
- XOR const_add[r] into the low 8 bits of s2;
- apply s_box per bit column, with s0 as the index MSB and s4 as the LSB;
- apply linear diffusion: si ^= rotr(si,a) ^ rotr(si,b), with (a,b) = s0 (19,28), s1 (61,39), s2 (1,6), s3 (10,17), s4 (7,41).
REQ-020 SHALL hold state_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on DONE with out_ready=1 and in_valid=0, clear out_valid and return to IDLE.
REQ-022 SHALL, on DONE with out_ready=1 and in_valid=1, accept the new job in the same cycle and enter RUN (back-to-back, no bubble).
REQ-023 SHALL ignore in_valid and mode while in RUN.
REQ-024 SHALL sample mode only on the input-handshake edge.
REQ-025 SHALL drive busy = (RUN).
REQ-026 SHALL drive state_out directly from the state register.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force FSM=IDLE, state register=0, r=0 and out_valid=0.
REQ-028 SHALL, while rst_n=0, drive state_out=0, busy=0 and in_ready=0.
REQ-029 SHALL drive in_ready=1 from the first edge after rst_n deasserts.
REQ-030 SHALL, on reset asserted during RUN or DONE, discard the job with no output handshake; after release, out_valid stays 0 until a new job completes.

Structure
REQ-031 SHALL add to ascon_aead128_pkg:
- enum ascon_perm_mode (P12, P8, P6);
- enum ascon_perm_fsm_state (IDLE, RUN, DONE);
- localparam P6_INIT = 4'hA.
REQ-032 SHALL reuse the existing package items const_add, s_box, ascon_state, round, P8_INIT and P12_INIT.
REQ-033 SHALL instantiate combinational sub-module ascon_round (inputs ascon_state and round constant; output ascon_state) UNROLL times in a chain, with a per-stage bypass mux.

Verification
REQ-034 SHALL cover: UNROLL=1, mode=p12, state_in=0, out_ready=1 -> out_valid exactly 12 cycles after handshake; state_out matches the Ascon C reference p12(0); first constant used 0xF0.
REQ-035 SHALL cover: UNROLL=3, mode=p8, random state -> out_valid after 3 cycles (3+3+2 rounds); result equal to the UNROLL=1 run of the same input; first constant 0xB4.
REQ-036 SHALL cover: UNROLL=4, mode=p6 -> out_valid after 2 cycles (4+2); mode=3 -> identical result and timing to p12 (3 cycles).
REQ-037 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> state_out and out_valid unchanged, in_ready=0, busy=0.
REQ-038 SHALL cover: in_valid held 1 with out_ready=1, UNROLL=2, p12 -> results every 6 cycles, no idle cycle between jobs.
REQ-039 SHALL cover: rst_n pulsed low mid-RUN -> state_out=0, out_valid=0, busy=0 immediately; in_ready=1 on the first edge after release.
